// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the memory responder and its storage array.
//   state_t          : responder FSM states (IDLE, WAIT, ACK)
//   ADDR_W_DEFAULT   : default word-address width (4096-word space)
//   DATA_W_DEFAULT   : default word width
//   WAIT_W           : width of the wait-state counter (supports 0..15)
//   TXN_W            : width of the completed-transaction counter
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int ADDR_W_DEFAULT = 12;
  localparam int DATA_W_DEFAULT = 16;
  localparam int WAIT_W         = 4;
  localparam int TXN_W          = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage : mem_pkg

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Synchronous single-port word array, DATA_W x 2^ADDR_W, with a registered
// read port. A write leaves the read register untouched.
//   clk   : clock, all updates on the rising edge
//   en    : access enable; nothing happens on an edge with en=0
//   we    : 1 = write wdata to addr, 0 = read addr into rdata
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, holds until the next enabled read
// -----------------------------------------------------------------------------
module mem_array #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // NOTE: the storage array and its read register have no reset; a reset
  // loop over thousands of words cannot map onto RAM macros, and memory
  // contents must survive rst anyway.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule : mem_array

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the basic-computer datapath. Serves single-word
// reads and writes over a four-phase req/ack handshake, inserting WAIT_CYCLES
// wait states before each access commits.
//   clk       : single clock, rising-edge
//   rst       : synchronous, active-high reset (memory contents unaffected)
//   req       : request from initiator, four-phase handshake
//   we        : 1 = write, 0 = read; sampled with req
//   addr      : word address; sampled with req
//   wdata     : write data; sampled with req
//   ack       : request complete; held until req is sampled low
//   rdata     : read data, valid while ack=1 for reads, held otherwise
//   busy      : high in WAIT and ACK
//   txn_count : completed transactions, wraps 0xFFFF -> 0x0000
//
// Timing: req sampled high at edge k gives ack=1 after edge k+WAIT_CYCLES+1.
// The FSM always passes through WAIT, even with WAIT_CYCLES=0: that one cycle
// is where the latched request commits, which is what makes the zero-wait
// ack appear one edge after the request.
// -----------------------------------------------------------------------------
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [TXN_W-1:0]  txn_count
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

  state_t              state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                latch;
  logic                commit;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_rdata;

  assign latch  = (state == IDLE) && req;
  assign commit = (state == WAIT) && (wait_cnt == '0);

  // The array is read on the latch edge using the live address, so its
  // registered output already holds mem[addr_q] by the commit edge, however
  // short the wait. Only this transaction can write the array before commit,
  // and only for writes, which never use the read value.
  // Writes are gated by rst so an access abandoned by reset never lands.
  assign mem_we   = commit && we_q && !rst;
  assign mem_en   = latch || mem_we;
  assign mem_addr = (state == IDLE) ? addr : addr_q;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // NOTE: sequential state is assigned with non-blocking (<=) only, so every
  // register here sees pre-edge values of the others regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ack       <= 1'b0;
      busy      <= 1'b0;
      rdata     <= '0;
      txn_count <= '0;
      wait_cnt  <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q     <= we;
            addr_q   <= addr;
            wdata_q  <= wdata;
            wait_cnt <= WAIT_INIT;
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end

        // req and the request inputs are ignored here; only the latched
        // copies matter.
        WAIT: begin
          if (wait_cnt == '0) begin
            if (!we_q) begin
              rdata <= mem_rdata;
            end
            txn_count <= txn_count + 1'b1;
            ack       <= 1'b1;
            state     <= ACK;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        // Stay here for as long as req is held so a held request is served
        // exactly once.
        ACK: begin
          if (!req) begin
            ack   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          ack   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Self-checking bench for mem_responder. Two instances share clk and rst:
// dut (WAIT_CYCLES=2) and dut0 (WAIT_CYCLES=0). Stimulus pushes the expected
// rdata/txn_count for each transaction into a queue; a monitor pops and
// compares whenever ack rises.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;

  logic        req, we;
  logic [11:0] addr;
  logic [15:0] wdata;
  logic        ack, busy;
  logic [15:0] rdata, txn_count;

  logic        req0, we0;
  logic [11:0] addr0;
  logic [15:0] wdata0;
  logic        ack0, busy0;
  logic [15:0] rdata0, txn_count0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] rdata;
    logic [15:0] txn;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp0_q[$];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(12), .DATA_W(16), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .txn_count(txn_count)
  );

  mem_responder #(.ADDR_W(12), .DATA_W(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ack(ack0), .rdata(rdata0), .busy(busy0), .txn_count(txn_count0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares on every rising edge of ack.
  logic ack_d  = 1'b0;
  logic ack0_d = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (ack === 1'b1 && ack_d !== 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_ack: dut ack rose with no transaction pending");
      end else begin
        e = exp_q.pop_front();
        check("sb_rdata", 32'(rdata), 32'(e.rdata));
        check("sb_txn_count", 32'(txn_count), 32'(e.txn));
      end
    end
    if (ack0 === 1'b1 && ack0_d !== 1'b1) begin
      if (exp0_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_ack0: dut0 ack rose with no transaction pending");
      end else begin
        e = exp0_q.pop_front();
        check("sb0_rdata", 32'(rdata0), 32'(e.rdata));
        check("sb0_txn_count", 32'(txn_count0), 32'(e.txn));
      end
    end
    ack_d  = ack;
    ack0_d = ack0;
  end

  // Waits (bounded) for dut ack after the latch edge and checks the edge count.
  task automatic wait_ack(input string tag, input int exp_edges);
    int n;
    n = 0;
    while (ack !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_edges));
    check({tag, "_busy_in_ack"}, 32'(busy), 32'd1);
  endtask

  // Full handshake on dut. Inputs are scrambled right after the latch edge;
  // the stored access must still use the latched values.
  task automatic run_txn(input string tag, input logic w, input logic [11:0] a,
                         input logic [15:0] d, input logic [15:0] exp_rd,
                         input logic [15:0] exp_cnt, input int hold);
    exp_t e;
    logic held_ok;
    e.rdata = exp_rd;
    e.txn   = exp_cnt;
    exp_q.push_back(e);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    we = ~w; addr = ~a; wdata = ~d;
    wait_ack(tag, 3);
    held_ok = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (ack !== 1'b1 || txn_count !== exp_cnt || rdata !== exp_rd) held_ok = 1'b0;
    end
    if (hold > 0) check({tag, "_held_req_stable"}, 32'(held_ok), 32'd1);
    req = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ack_drop"}, 32'(ack), 32'd0);
    check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    check({tag, "_txn_after"}, 32'(txn_count), 32'(exp_cnt));
    check({tag, "_rdata_idle_hold"}, 32'(rdata), 32'(exp_rd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    logic seen;

    rst = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;

    dut.u_array.mem[12'h010]  = 16'h7123;
    dut.u_array.mem[12'h200]  = 16'h1111;
    dut0.u_array.mem[12'h03C] = 16'h5A5A;

    // Reset state after two reset edges.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_txn_count", 32'(txn_count), 32'h0);
    check("rst_state", 32'(dut.state), 32'd0);

    // rst and req on the same edge: request must not be latched.
    req = 1'b1; we = 1'b0; addr = 12'h010;
    @(posedge clk); #1;
    check("rst_req_busy", 32'(busy), 32'd0);
    check("rst_req_state", 32'(dut.state), 32'd0);
    rst = 1'b0; req = 1'b0;
    @(posedge clk); #1;
    check("rst_req_still_idle", 32'(dut.state), 32'd0);

    // Reset during WAIT abandons the write.
    req = 1'b1; we = 1'b1; addr = 12'h200; wdata = 16'h2222;
    @(posedge clk); #1;               // latch edge
    req = 1'b0;
    check("rstwait_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;               // first WAIT edge
    rst = 1'b1;
    @(posedge clk); #1;               // second WAIT edge, reset applied
    rst = 1'b0;
    check("rstwait_state", 32'(dut.state), 32'd0);
    check("rstwait_busy_after", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack !== 1'b0) seen = 1'b1;
    end
    check("rstwait_no_ack", 32'(seen), 32'd0);
    check("rstwait_mem_kept", 32'(dut.u_array.mem[12'h200]), 32'h1111);
    check("rstwait_txn_count", 32'(txn_count), 32'h0);

    // Read with two wait states.
    run_txn("read_010", 1'b0, 12'h010, 16'h0000, 16'h7123, 16'd1, 0);
    // Write; rdata keeps the previous read value.
    run_txn("write_0a5", 1'b1, 12'h0A5, 16'hBEEF, 16'h7123, 16'd2, 0);
    // Read-back with req held for 10 cycles after ack.
    run_txn("readback_0a5", 1'b0, 12'h0A5, 16'h0000, 16'hBEEF, 16'd3, 10);
    check("scramble_addr_untouched", 32'(dut.u_array.mem[12'hF5A]), 32'(16'hxxxx) & 32'h0);

    // Reset while in ACK after a write: write persists, rdata cleared.
    e.rdata = 16'hBEEF; e.txn = 16'd4;
    exp_q.push_back(e);
    req = 1'b1; we = 1'b1; addr = 12'h0C0; wdata = 16'h1234;
    @(posedge clk); #1;
    wait_ack("rstack_write", 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    check("rstack_ack", 32'(ack), 32'd0);
    check("rstack_rdata", 32'(rdata), 32'h0);
    check("rstack_txn_count", 32'(txn_count), 32'h0);
    run_txn("read_0c0", 1'b0, 12'h0C0, 16'h0000, 16'h1234, 16'd1, 0);

    // Zero wait states and counter wrap on dut0.
    force dut0.txn_count = 16'hFFFF;
    #1;
    release dut0.txn_count;
    e.rdata = 16'h5A5A; e.txn = 16'h0000;
    exp0_q.push_back(e);
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h03C;
    @(posedge clk); #1;
    n = 0;
    while (ack0 !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("zw_latency", 32'(n), 32'd1);
    check("zw_rdata", 32'(rdata0), 32'h5A5A);
    check("zw_wrap", 32'(txn_count0), 32'h0000);
    req0 = 1'b0;
    @(posedge clk); #1;
    check("zw_ack_drop", 32'(ack0), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("sb0_drained", 32'(exp0_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mem_responder
